// File: rtl/alu_fu_if.sv
// Issue / CDB handshake bundle for the integer ALU functional unit.
// The slave side is the ALU; the master side is the RS + CDB arbiter.
interface alu_fu_if #(
    parameter int WIDTH = 32,
    parameter int ROB_W = 4
);
    logic             flush;
    logic             valid_in;
    logic             ready;
    logic [3:0]       op;
    logic [2:0]       branch_type;
    logic [ROB_W-1:0] rs_rob_entry;
    logic [WIDTH-1:0] rs1;
    logic [WIDTH-1:0] rs2;
    logic             valid_out;
    logic             yumi_in;
    logic [ROB_W-1:0] out_rob;
    logic [WIDTH-1:0] out_result;
    logic             out_branch_taken;
    logic             out_from_memory;

    modport slave (
        input  flush, valid_in, op, branch_type, rs_rob_entry,
        input  rs1, rs2, yumi_in,
        output ready, valid_out, out_rob, out_result,
        output out_branch_taken, out_from_memory
    );

    modport master (
        output flush, valid_in, op, branch_type, rs_rob_entry,
        output rs1, rs2, yumi_in,
        input  ready, valid_out, out_rob, out_result,
        input  out_branch_taken, out_from_memory
    );
endinterface

// File: rtl/alu_fu.sv
// Pipelined integer ALU functional unit: evaluates at issue, carries the
// tagged result through STAGES stallable stages to a valid/yumi CDB port.
module alu_fu #(
    parameter int WIDTH  = 32,
    parameter int ROB_W  = 4,
    parameter int STAGES = 2
) (
    input logic   clk,
    input logic   reset,
    alu_fu_if.slave io
);
    localparam int SHW = $clog2(WIDTH);

    typedef struct packed {
        logic [ROB_W-1:0] rob;
        logic [WIDTH-1:0] res;
        logic             tkn;
    } stage_t;

    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   d;
    logic               zero;
    logic               ovf;
    logic               lt_s;
    logic               lt_u;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   res;
    logic               tkn;
    logic               accept;

    logic [STAGES-1:0]  v_q;
    logic [STAGES-1:0]  v_d;
    logic [STAGES-1:0]  adv;
    stage_t             st_q [STAGES];
    stage_t             st_d [STAGES];

    // One subtractor serves SUB, SLT/SLTU and every branch condition.
    always_comb begin
        diff  = {1'b0, io.rs1} - {1'b0, io.rs2};
        d     = diff[WIDTH-1:0];
        zero  = (d == '0);
        ovf   = (io.rs1[WIDTH-1] ^ io.rs2[WIDTH-1]) &
                (d[WIDTH-1] ^ io.rs1[WIDTH-1]);
        lt_s  = d[WIDTH-1] ^ ovf;
        lt_u  = diff[WIDTH];
        shamt = io.rs2[SHW-1:0];
        res   = '0;
        case (io.op)
            4'd0:    res = io.rs1 + io.rs2;
            4'd1:    res = d;
            4'd2:    res = io.rs1 & io.rs2;
            4'd3:    res = io.rs1 | io.rs2;
            4'd4:    res = io.rs1 ^ io.rs2;
            4'd5:    res = {{(WIDTH-1){1'b0}}, lt_s};
            4'd6:    res = {{(WIDTH-1){1'b0}}, lt_u};
            4'd7:    res = io.rs1 << shamt;
            4'd8:    res = io.rs1 >> shamt;
            4'd9:    res = $signed(io.rs1) >>> shamt;
            default: res = '0;
        endcase
        tkn = 1'b0;
        case (io.branch_type)
            3'd1:    tkn = zero;
            3'd2:    tkn = ~zero;
            3'd3:    tkn = lt_s;
            3'd4:    tkn = ~lt_s;
            3'd5:    tkn = lt_u;
            3'd6:    tkn = ~lt_u;
            default: tkn = 1'b0;
        endcase
    end

    // A stage may move when it is empty or everything below it moves.
    always_comb begin
        adv[STAGES-1] = ~v_q[STAGES-1] | io.yumi_in;
        for (int i = STAGES - 2; i >= 0; i--) begin
            adv[i] = ~v_q[i] | adv[i+1];
        end
    end

    assign io.ready = ~io.flush & adv[0];
    assign accept   = io.valid_in & io.ready;

    always_comb begin
        v_d  = v_q;
        st_d = st_q;
        if (adv[0]) begin
            v_d[0] = accept;
            if (accept) begin
                st_d[0].rob = io.rs_rob_entry;
                st_d[0].res = res;
                st_d[0].tkn = tkn;
            end
        end
        for (int i = 1; i < STAGES; i++) begin
            if (adv[i]) begin
                v_d[i] = v_q[i-1];
                if (v_q[i-1]) begin
                    st_d[i] = st_q[i-1];
                end
            end
        end
        if (io.flush) begin
            v_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                st_q[i] <= '0;
            end
        end else begin
            v_q  <= v_d;
            st_q <= st_d;
        end
    end

    assign io.valid_out        = v_q[STAGES-1];
    assign io.out_rob          = st_q[STAGES-1].rob;
    assign io.out_result       = st_q[STAGES-1].res;
    assign io.out_branch_taken = st_q[STAGES-1].tkn;
    assign io.out_from_memory  = 1'b0;
endmodule

// File: tb/tb_alu_fu.sv
// Self-checking bench for alu_fu: directed scenarios on three
// configurations plus a randomized scoreboard run on the 3-stage unit.
module tb_alu_fu;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_fu_if #(.WIDTH(32), .ROB_W(4)) a2 ();
    alu_fu_if #(.WIDTH(32), .ROB_W(4)) a3 ();
    alu_fu_if #(.WIDTH(16), .ROB_W(4)) a1 ();

    alu_fu #(.WIDTH(32), .ROB_W(4), .STAGES(2)) u2 (
        .clk(clk), .reset(rst), .io(a2.slave));
    alu_fu #(.WIDTH(32), .ROB_W(4), .STAGES(3)) u3 (
        .clk(clk), .reset(rst), .io(a3.slave));
    alu_fu #(.WIDTH(16), .ROB_W(4), .STAGES(1)) u1 (
        .clk(clk), .reset(rst), .io(a1.slave));

    typedef struct {
        logic [3:0]  rob;
        logic [32:0] rt;
    } exp_t;

    exp_t q[$];

    // Reference: {taken, result} from plain integer arithmetic.
    function automatic logic [32:0] model(input int w, input logic [3:0] op,
                                          input logic [2:0] bt,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint unsigned mask, ua, ub, r;
        longint sa, sb;
        int sh;
        logic t;
        mask = (64'd1 << w) - 64'd1;
        ua = {32'd0, a} & mask;
        ub = {32'd0, b} & mask;
        sa = (ua >= (64'd1 << (w - 1))) ? longint'(ua) - longint'(64'd1 << w)
                                       : longint'(ua);
        sb = (ub >= (64'd1 << (w - 1))) ? longint'(ub) - longint'(64'd1 << w)
                                       : longint'(ub);
        sh = int'(ub % longint'(w));
        case (op)
            4'd0: r = ua + ub;
            4'd1: r = ua - ub;
            4'd2: r = ua & ub;
            4'd3: r = ua | ub;
            4'd4: r = ua ^ ub;
            4'd5: r = (sa < sb) ? 64'd1 : 64'd0;
            4'd6: r = (ua < ub) ? 64'd1 : 64'd0;
            4'd7: r = ua << sh;
            4'd8: r = ua >> sh;
            4'd9: r = longint'(sa >>> sh);
            default: r = 64'd0;
        endcase
        r = r & mask;
        case (bt)
            3'd1: t = (ua == ub);
            3'd2: t = (ua != ub);
            3'd3: t = (sa < sb);
            3'd4: t = (sa >= sb);
            3'd5: t = (ua < ub);
            3'd6: t = (ua >= ub);
            default: t = 1'b0;
        endcase
        return {t, r[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Issue one op on the 2-stage unit and collect its output.
    task automatic op2(input logic [3:0] op, input logic [2:0] bt,
                       input logic [31:0] x, input logic [31:0] y,
                       output logic [32:0] got);
        bit seen = 0;
        a2.valid_in = 1'b1;
        a2.op = op;
        a2.branch_type = bt;
        a2.rs1 = x;
        a2.rs2 = y;
        a2.rs_rob_entry = 4'd3;
        tick();
        a2.valid_in = 1'b0;
        got = '0;
        for (int n = 0; n < 6 && !seen; n++) begin
            if (a2.valid_out) begin
                seen = 1;
                got = {a2.out_branch_taken, a2.out_result};
                a2.yumi_in = 1'b1;
            end
            tick();
        end
        a2.yumi_in = 1'b0;
        chk("op2_seen", 64'(seen), 64'd1);
    endtask

    task automatic op1(input logic [3:0] op, input logic [15:0] x,
                       input logic [15:0] y, output logic [15:0] got);
        bit seen = 0;
        a1.valid_in = 1'b1;
        a1.op = op;
        a1.branch_type = 3'd0;
        a1.rs1 = x;
        a1.rs2 = y;
        a1.rs_rob_entry = 4'd2;
        tick();
        a1.valid_in = 1'b0;
        got = '0;
        for (int n = 0; n < 4 && !seen; n++) begin
            if (a1.valid_out) begin
                seen = 1;
                got = a1.out_result;
                a1.yumi_in = 1'b1;
            end
            tick();
        end
        a1.yumi_in = 1'b0;
        chk("op1_seen", 64'(seen), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [32:0] g;
        logic [15:0] s;
        logic [32:0] m;
        exp_t e;
        bit vo;

        rst = 1'b1;
        a1.flush = 0; a1.valid_in = 0; a1.yumi_in = 0; a1.op = 0;
        a1.branch_type = 0; a1.rs_rob_entry = 0; a1.rs1 = 0; a1.rs2 = 0;
        a2.flush = 0; a2.valid_in = 0; a2.yumi_in = 0; a2.op = 0;
        a2.branch_type = 0; a2.rs_rob_entry = 0; a2.rs1 = 0; a2.rs2 = 0;
        a3.flush = 0; a3.valid_in = 0; a3.yumi_in = 0; a3.op = 0;
        a3.branch_type = 0; a3.rs_rob_entry = 0; a3.rs1 = 0; a3.rs2 = 0;
        #2;
        chk("rst_valid_out", 64'(a2.valid_out), 64'd0);
        chk("rst_out_rob", 64'(a2.out_rob), 64'd0);
        chk("rst_out_result", 64'(a2.out_result), 64'd0);
        chk("rst_taken", 64'(a2.out_branch_taken), 64'd0);
        chk("rst_from_mem", 64'(a2.out_from_memory), 64'd0);
        chk("rst_ready", 64'(a3.ready), 64'd1);
        tick();
        tick();
        rst = 1'b0;

        // Basic latency on 2 stages with yumi tied high.
        a2.yumi_in = 1'b1;
        a2.valid_in = 1'b1;
        a2.op = 4'd0;
        a2.rs1 = 32'h7FFF_FFFF;
        a2.rs2 = 32'h1;
        a2.rs_rob_entry = 4'd5;
        #1;
        chk("lat_ready", 64'(a2.ready), 64'd1);
        tick();
        a2.valid_in = 1'b0;
        chk("lat_early", 64'(a2.valid_out), 64'd0);
        tick();
        chk("lat_valid", 64'(a2.valid_out), 64'd1);
        chk("lat_result", 64'(a2.out_result), 64'h8000_0000);
        chk("lat_rob", 64'(a2.out_rob), 64'd5);
        chk("lat_taken", 64'(a2.out_branch_taken), 64'd0);
        tick();
        chk("lat_once", 64'(a2.valid_out), 64'd0);
        a2.yumi_in = 1'b0;

        // Branch matrix.
        op2(4'd1, 3'd3, 32'hFFFF_FFFF, 32'h1, g);
        chk("blt_taken", 64'(g[32]), 64'd1);
        chk("blt_result", 64'(g[31:0]), 64'hFFFF_FFFE);
        op2(4'd1, 3'd5, 32'hFFFF_FFFF, 32'h1, g);
        chk("bltu_taken", 64'(g[32]), 64'd0);
        op2(4'd1, 3'd4, 32'hFFFF_FFFF, 32'h1, g);
        chk("bge_taken", 64'(g[32]), 64'd0);
        op2(4'd1, 3'd6, 32'hFFFF_FFFF, 32'h1, g);
        chk("bgeu_taken", 64'(g[32]), 64'd1);
        op2(4'd1, 3'd1, 32'h1234, 32'h1234, g);
        chk("beq_taken", 64'(g[32]), 64'd1);
        chk("beq_result", 64'(g[31:0]), 64'd0);
        op2(4'd1, 3'd2, 32'h1234, 32'h1234, g);
        chk("bne_taken", 64'(g[32]), 64'd0);
        op2(4'd5, 3'd7, 32'h8000_0000, 32'h1, g);
        chk("slt_bt7", 64'(g), 64'h0_0000_0001);

        // Shifts on the 16-bit single-stage unit.
        op1(4'd9, 16'h8001, 16'h0011, s);
        chk("sra", 64'(s), 64'hC000);
        op1(4'd8, 16'h8001, 16'h0001, s);
        chk("srl", 64'(s), 64'h4000);
        op1(4'd7, 16'h8001, 16'h000F, s);
        chk("sll", 64'(s), 64'h8000);
        op1(4'd12, 16'h8001, 16'h000F, s);
        chk("op12_zero", 64'(s), 64'h0);

        // Back-pressure on 3 stages.
        a3.op = 4'd4;
        a3.rs1 = 32'h0;
        a3.rs2 = 32'h0;
        for (int t = 1; t <= 3; t++) begin
            a3.valid_in = 1'b1;
            a3.rs_rob_entry = 4'(t);
            #1;
            chk("bp_ready_fill", 64'(a3.ready), 64'd1);
            tick();
        end
        a3.rs_rob_entry = 4'd4;
        for (int n = 0; n < 3; n++) begin
            #1;
            chk("bp_ready_full", 64'(a3.ready), 64'd0);
            chk("bp_hold_valid", 64'(a3.valid_out), 64'd1);
            chk("bp_hold_rob", 64'(a3.out_rob), 64'd1);
            tick();
        end
        for (int t = 1; t <= 4; t++) begin
            a3.yumi_in = 1'b1;
            chk("bp_drain_valid", 64'(a3.valid_out), 64'd1);
            chk("bp_drain_rob", 64'(a3.out_rob), 64'(t));
            #1;
            if (t == 1) chk("bp_nobubble", 64'(a3.ready), 64'd1);
            tick();
            a3.valid_in = 1'b0;
        end
        a3.yumi_in = 1'b0;
        chk("bp_empty", 64'(a3.valid_out), 64'd0);

        // Flush with pipeline full.
        for (int t = 8; t <= 10; t++) begin
            a3.valid_in = 1'b1;
            a3.rs_rob_entry = 4'(t);
            tick();
        end
        a3.valid_in = 1'b0;
        #1;
        chk("fl_full", 64'(a3.ready), 64'd0);
        a3.flush = 1'b1;
        a3.valid_in = 1'b1;
        a3.rs_rob_entry = 4'd13;
        #1;
        chk("fl_ready0", 64'(a3.ready), 64'd0);
        tick();
        a3.flush = 1'b0;
        a3.valid_in = 1'b0;
        chk("fl_killed", 64'(a3.valid_out), 64'd0);
        #1;
        chk("fl_ready1", 64'(a3.ready), 64'd1);
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("fl_none", 64'(a3.valid_out), 64'd0);
        end

        // Asynchronous reset with work in flight.
        for (int t = 11; t <= 13; t++) begin
            a3.valid_in = 1'b1;
            a3.rs_rob_entry = 4'(t);
            tick();
        end
        a3.valid_in = 1'b0;
        chk("ar_pre_valid", 64'(a3.valid_out), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid0", 64'(a3.valid_out), 64'd0);
        chk("ar_rob0", 64'(a3.out_rob), 64'd0);
        tick();
        rst = 1'b0;
        a3.valid_in = 1'b1;
        a3.rs_rob_entry = 4'd6;
        #1;
        chk("ar_ready", 64'(a3.ready), 64'd1);
        tick();
        a3.valid_in = 1'b0;
        chk("ar_lat0", 64'(a3.valid_out), 64'd0);
        tick();
        chk("ar_lat1", 64'(a3.valid_out), 64'd0);
        tick();
        chk("ar_lat2", 64'(a3.valid_out), 64'd1);
        chk("ar_rob", 64'(a3.out_rob), 64'd6);
        a3.yumi_in = 1'b1;
        tick();
        a3.yumi_in = 1'b0;

        // Randomized run against the scoreboard.
        for (int c = 0; c < 600; c++) begin
            vo = a3.valid_out;
            if (vo) begin
                chk("rnd_nonempty", 64'(q.size() > 0), 64'd1);
                if (q.size() > 0) begin
                    chk("rnd_rob", 64'(a3.out_rob), 64'(q[0].rob));
                    chk("rnd_res", 64'({a3.out_branch_taken, a3.out_result}),
                        64'(q[0].rt));
                end
            end
            a3.flush = ($urandom % 40) == 0;
            a3.yumi_in = vo & (($urandom % 3) != 0);
            a3.valid_in = ($urandom % 4) != 0;
            a3.op = 4'($urandom);
            a3.branch_type = 3'($urandom);
            a3.rs1 = pick();
            a3.rs2 = (($urandom % 5) == 0) ? a3.rs1 : pick();
            a3.rs_rob_entry = 4'($urandom);
            #1;
            chk("rnd_ready", 64'(a3.ready),
                64'(!a3.flush && (q.size() < 3 || a3.yumi_in)));
            if (a3.yumi_in && q.size() > 0) void'(q.pop_front());
            if (a3.valid_in && a3.ready) begin
                m = model(32, a3.op, a3.branch_type, a3.rs1, a3.rs2);
                e.rob = a3.rs_rob_entry;
                e.rt = m;
                q.push_back(e);
            end
            if (a3.flush) q.delete();
            tick();
        end
        a3.flush = 1'b0;
        a3.valid_in = 1'b0;
        for (int n = 0; n < 12; n++) begin
            a3.yumi_in = 1'b0;
            if (a3.valid_out && q.size() > 0) begin
                chk("drain_rob", 64'(a3.out_rob), 64'(q[0].rob));
                chk("drain_res", 64'({a3.out_branch_taken, a3.out_result}),
                    64'(q[0].rt));
                a3.yumi_in = 1'b1;
                void'(q.pop_front());
            end
            tick();
        end
        a3.yumi_in = 1'b0;
        chk("drain_done", 64'(q.size()), 64'd0);
        chk("drain_idle", 64'(a3.valid_out), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
